// File: rtl/dpopt_expr_pipe.sv
// dpopt_expr_pipe: three-stage expression datapath reducing NCH unsigned
// channels to one result (sum, pairwise sum-of-products, pairwise sum of
// absolute differences, or maximum), selected per transaction.
//
// Handshake: an input word transfers on a rising edge with din_vld=1 and
// din_busy=0; a result transfers on a rising edge with dout_vld=1 and
// dout_busy=0. A stall (dout_vld & dout_busy) freezes every stage, so at
// most one transaction sits in each of S1, S2 and S3.
module dpopt_expr_pipe #(
    parameter int NCH = 8,
    parameter int DW  = 8,
    parameter int OW  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_vld,
    output logic                din_busy,
    input  logic [NCH*DW-1:0]   din_data,
    input  logic [1:0]          din_mode,
    output logic                dout_vld,
    input  logic                dout_busy,
    output logic [OW-1:0]       dout_data,
    output logic                dout_ovf
);

    localparam int NP    = NCH / 2;
    localparam int W_SUM = DW + $clog2(NCH);
    localparam int W_SOP = 2 * DW + $clog2(NP);
    localparam int W_SAD = DW + $clog2(NP);
    localparam int W_A   = (W_SOP > W_SUM) ? W_SOP : W_SUM;
    // Full-precision width: wide enough for every mode's exact result.
    localparam int FW    = (W_SAD > W_A) ? W_SAD : W_A;
    // Working width for the output stage; zero-extends when OW > FW.
    localparam int XW    = (OW > FW) ? OW : FW;

    localparam logic [1:0] MODE_SUM = 2'b00;
    localparam logic [1:0] MODE_SOP = 2'b01;
    localparam logic [1:0] MODE_SAD = 2'b10;
    localparam logic [1:0] MODE_MAX = 2'b11;

    logic stall;

    // Pair operands straight off the input bus.
    logic [DW-1:0] ch_a [NP];
    logic [DW-1:0] ch_b [NP];

    for (genvar j = 0; j < NP; j++) begin : g_pair
        assign ch_a[j] = din_data[(2*j)*DW +: DW];
        assign ch_b[j] = din_data[(2*j+1)*DW +: DW];
    end

    // S1 per-pair terms.
    logic [DW:0]       s1_psum  [NP];
    logic [2*DW-1:0]   s1_prod  [NP];
    logic [DW-1:0]     s1_adiff [NP];
    logic [DW-1:0]     s1_pmax  [NP];
    logic [1:0]        s1_mode;
    logic              s1_vld;

    // S2 reduced full-precision result.
    logic [FW-1:0]     s2_full;
    logic              s2_vld;

    // Mode-selected reduction of the S1 terms.
    logic [FW-1:0]     red_sum;
    logic [FW-1:0]     red_sop;
    logic [FW-1:0]     red_sad;
    logic [DW-1:0]     red_max;
    logic [FW-1:0]     red_full;

    // Output-stage view of the S2 result at the working width.
    logic [XW-1:0]     full_x;

    assign stall    = dout_vld & dout_busy;
    assign din_busy = stall | ~rst;
    assign full_x   = XW'(s2_full);

    // S1: register per-pair sum, product, abs diff and max of an accepted word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s1_mode <= 2'b00;
            for (int j = 0; j < NP; j++) begin
                s1_psum[j]  <= '0;
                s1_prod[j]  <= '0;
                s1_adiff[j] <= '0;
                s1_pmax[j]  <= '0;
            end
        end else if (!stall) begin
            s1_vld <= din_vld;
            if (din_vld) begin
                s1_mode <= din_mode;
                for (int j = 0; j < NP; j++) begin
                    s1_psum[j]  <= {1'b0, ch_a[j]} + {1'b0, ch_b[j]};
                    s1_prod[j]  <= (2*DW)'(ch_a[j]) * (2*DW)'(ch_b[j]);
                    s1_adiff[j] <= (ch_a[j] > ch_b[j]) ? (ch_a[j] - ch_b[j])
                                                       : (ch_b[j] - ch_a[j]);
                    s1_pmax[j]  <= (ch_a[j] > ch_b[j]) ? ch_a[j] : ch_b[j];
                end
            end
        end
    end

    // Adder/max trees over the pair terms, then select by the word's own mode.
    always_comb begin
        red_sum  = '0;
        red_sop  = '0;
        red_sad  = '0;
        red_max  = '0;
        red_full = '0;
        for (int j = 0; j < NP; j++) begin
            red_sum = red_sum + FW'(s1_psum[j]);
            red_sop = red_sop + FW'(s1_prod[j]);
            red_sad = red_sad + FW'(s1_adiff[j]);
            if (s1_pmax[j] > red_max) red_max = s1_pmax[j];
        end
        case (s1_mode)
            MODE_SUM: red_full = red_sum;
            MODE_SOP: red_full = red_sop;
            MODE_SAD: red_full = red_sad;
            MODE_MAX: red_full = FW'(red_max);
            default:  red_full = '0;
        endcase
    end

    // S2: hold the full-precision reduction; bubbles advance without data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld  <= 1'b0;
            s2_full <= '0;
        end else if (!stall) begin
            s2_vld <= s1_vld;
            if (s1_vld) s2_full <= red_full;
        end
    end

    // S3: truncate to OW and flag any bits lost above it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_vld  <= 1'b0;
            dout_data <= '0;
            dout_ovf  <= 1'b0;
        end else if (!stall) begin
            dout_vld <= s2_vld;
            if (s2_vld) begin
                dout_data <= full_x[OW-1:0];
                dout_ovf  <= |(full_x >> OW);
            end
        end
    end

endmodule

// File: tb/tb_dpopt_expr_pipe.sv
// tb_dpopt_expr_pipe: directed and random stimulus for dpopt_expr_pipe,
// checked against an arithmetic reference model through an expected queue.
// Three instances share the input channel: defaults, OW=16, and NCH=2/DW=4/OW=5
// (the last one sees only the low byte of din_data).
module tb_dpopt_expr_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        din_vld;
    logic [63:0] din_data;
    logic [1:0]  din_mode;
    logic        dout_busy;

    logic        din_busy, dout_vld, dout_ovf;
    logic [31:0] dout_data;
    logic        b16, v16, o16;
    logic [15:0] d16;
    logic        bs, vs, os;
    logic [4:0]  ds;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // {main data 32, main ovf, ow16 data 16, ow16 ovf, small data 5, small ovf}
    logic [55:0] exp_q[$];

    dpopt_expr_pipe #(.NCH(8), .DW(8), .OW(32)) u_dut (
        .clk(clk), .rst(rst),
        .din_vld(din_vld), .din_busy(din_busy), .din_data(din_data), .din_mode(din_mode),
        .dout_vld(dout_vld), .dout_busy(dout_busy), .dout_data(dout_data), .dout_ovf(dout_ovf)
    );

    dpopt_expr_pipe #(.NCH(8), .DW(8), .OW(16)) u_ow16 (
        .clk(clk), .rst(rst),
        .din_vld(din_vld), .din_busy(b16), .din_data(din_data), .din_mode(din_mode),
        .dout_vld(v16), .dout_busy(dout_busy), .dout_data(d16), .dout_ovf(o16)
    );

    dpopt_expr_pipe #(.NCH(2), .DW(4), .OW(5)) u_n2 (
        .clk(clk), .rst(rst),
        .din_vld(din_vld), .din_busy(bs), .din_data(din_data[7:0]), .din_mode(din_mode),
        .dout_vld(vs), .dout_busy(dout_busy), .dout_data(ds), .dout_ovf(os)
    );

    // ---------------- reference model ----------------
    function automatic longint unsigned ref_full(input logic [63:0] d, input int nch,
                                                 input int dw, input logic [1:0] mode);
        longint unsigned c[16];
        longint unsigned r;
        longint unsigned mask;
        mask = (64'd1 << dw) - 64'd1;
        r = 0;
        for (int i = 0; i < nch; i++) c[i] = (d >> (i * dw)) & mask;
        for (int i = 0; i < nch; i++) begin
            case (mode)
                2'd0: r = r + c[i];
                2'd1: if (i % 2 == 0) r = r + c[i] * c[i+1];
                2'd2: if (i % 2 == 0) r = r + ((c[i] > c[i+1]) ? c[i] - c[i+1] : c[i+1] - c[i]);
                default: if (c[i] > r) r = c[i];
            endcase
        end
        return r;
    endfunction

    function automatic logic [55:0] expect_word(input logic [63:0] d, input logic [1:0] m);
        longint unsigned f8;
        longint unsigned f2;
        f8 = ref_full(d, 8, 8, m);
        f2 = ref_full(d, 2, 4, m);
        return {f8[31:0], ((f8 >> 32) != 0), f8[15:0], ((f8 >> 16) != 0),
                f2[4:0], ((f2 >> 5) != 0)};
    endfunction

    // ---------------- comparison ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Inputs change #1 after a rising edge, so the falling edge sees exactly
    // what the next rising edge will transfer.
    always @(negedge clk) begin
        logic [55:0] e;
        if (rst && din_vld && !din_busy) exp_q.push_back(expect_word(din_data, din_mode));
        if (dout_vld && !dout_busy) begin
            chk("sb_expected_pending", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_main_data", dout_data, e[55:24]);
                chk("sb_main_ovf",  dout_ovf,  e[23]);
                chk("sb_ow16_vld",  v16,       1);
                chk("sb_ow16_data", d16,       e[22:7]);
                chk("sb_ow16_ovf",  o16,       e[6]);
                chk("sb_n2_vld",    vs,        1);
                chk("sb_n2_data",   ds,        e[5:1]);
                chk("sb_n2_ovf",    os,        e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Four back-to-back words with the same data, modes 0..3; each result is
    // expected on consecutive cycles, the first two edges after its transfer.
    task automatic run_four(input string tag, input logic [63:0] d,
                            input logic [3:0][31:0] e,   input logic [3:0] eo,
                            input logic [3:0][15:0] e16, input logic [3:0] eo16,
                            input logic [3:0][4:0]  es,  input logic [3:0] eos);
        for (int m = 0; m < 4; m++) begin
            @(posedge clk); #1;
            din_vld  = 1'b1;
            din_data = d;
            din_mode = 2'(m);
        end
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            chk($sformatf("%s_vld_m%0d", tag, m),      dout_vld,  1);
            chk($sformatf("%s_data_m%0d", tag, m),     dout_data, e[m]);
            chk($sformatf("%s_ovf_m%0d", tag, m),      dout_ovf,  eo[m]);
            chk($sformatf("%s_ow16_data_m%0d", tag, m), d16,      e16[m]);
            chk($sformatf("%s_ow16_ovf_m%0d", tag, m),  o16,      eo16[m]);
            chk($sformatf("%s_n2_data_m%0d", tag, m),   ds,       es[m]);
            chk($sformatf("%s_n2_ovf_m%0d", tag, m),    os,       eos[m]);
            @(posedge clk); #1;
            din_vld = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("%s_idle", tag), dout_vld, 0);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int issued;
        logic need_new;

        rst       = 1'b1;
        din_vld   = 1'b0;
        din_data  = '0;
        din_mode  = 2'b00;
        dout_busy = 1'b0;

        // Reset values.
        #2 rst = 1'b0;
        #1;
        chk("rst_dout_vld",  dout_vld,  0);
        chk("rst_dout_data", dout_data, 0);
        chk("rst_dout_ovf",  dout_ovf,  0);
        chk("rst_din_busy",  din_busy,  1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("release_din_busy", din_busy, 0);

        // Channels 1..8, all modes.
        run_four("ramp", 64'h0807_0605_0403_0201,
                 {32'd8, 32'd4, 32'd100, 32'd36}, 4'b0000,
                 {16'd8, 16'd4, 16'd100, 16'd36}, 4'b0000,
                 {5'd1, 5'd1, 5'd0, 5'd1},         4'b0000);

        // All channels at full scale: OW=16 overflows on sum of products.
        run_four("full", 64'hFFFF_FFFF_FFFF_FFFF,
                 {32'd255, 32'd0, 32'd260100, 32'd2040}, 4'b0000,
                 {16'd255, 16'd0, 16'd63492, 16'd2040},   4'b0010,
                 {5'd15, 5'd0, 5'd1, 5'd30},              4'b0010);

        // One channel at 15, rest zero (the NCH=2 case sees channels (15,0)).
        run_four("ch15", 64'h0000_0000_0000_000F,
                 {32'd15, 32'd15, 32'd0, 32'd15}, 4'b0000,
                 {16'd15, 16'd15, 16'd0, 16'd15}, 4'b0000,
                 {5'd15, 5'd15, 5'd0, 5'd15},     4'b0000);

        // All-zero input: max of nothing but zeros is zero.
        run_four("zero", 64'h0,
                 {32'd0, 32'd0, 32'd0, 32'd0}, 4'b0000,
                 {16'd0, 16'd0, 16'd0, 16'd0}, 4'b0000,
                 {5'd0, 5'd0, 5'd0, 5'd0},     4'b0000);
        drain("drain_directed");

        // Random stream of 20 words with the output stalled in cycles 5..9.
        c        = 0;
        issued   = 0;
        need_new = 1'b1;
        while ((issued < 20 || din_vld) && c < 80) begin
            @(posedge clk); #1;
            dout_busy = (c >= 5 && c <= 9);
            if (need_new) begin
                if (issued < 20) begin
                    din_vld  = 1'b1;
                    din_data = {$urandom, $urandom};
                    din_mode = 2'($urandom_range(0, 3));
                    issued++;
                end else begin
                    din_vld = 1'b0;
                end
            end
            @(negedge clk);
            chk($sformatf("stream_din_busy_c%0d", c), din_busy, (c >= 5 && c <= 9));
            if (c >= 5 && c <= 9) begin
                chk($sformatf("stall_vld_c%0d", c), dout_vld, 1);
                if (exp_q.size() != 0)
                    chk($sformatf("stall_hold_c%0d", c), dout_data, exp_q[0][55:24]);
            end
            need_new = !din_vld || !din_busy;
            c++;
        end
        chk("stream_issued", issued, 20);
        @(posedge clk); #1;
        dout_busy = 1'b0;
        drain("drain_stream");

        // Reset with three words in flight.
        @(posedge clk); #1;
        din_vld = 1'b1; din_data = 64'h0807_0605_0403_0201; din_mode = 2'd1;
        @(posedge clk); #1;
        din_mode = 2'd2;
        @(posedge clk); #1;
        din_mode = 2'd3;
        @(posedge clk); #1;
        din_vld = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("midrst_dout_vld",  dout_vld,  0);
        chk("midrst_dout_data", dout_data, 0);
        chk("midrst_dout_ovf",  dout_ovf,  0);
        chk("midrst_din_busy",  din_busy,  1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("midrst_release_busy", din_busy, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_no_stale_%0d", i), dout_vld, 0);
        end

        // Fresh word after reset: visible two edges after its transfer edge.
        @(posedge clk); #1;
        din_vld = 1'b1; din_data = 64'h0807_0605_0403_0201; din_mode = 2'd0;
        @(posedge clk); #1;
        din_vld = 1'b0;
        @(negedge clk);
        chk("post_rst_lat_e0", dout_vld, 0);
        @(negedge clk);
        chk("post_rst_lat_e1", dout_vld, 0);
        @(negedge clk);
        chk("post_rst_lat_vld",  dout_vld,  1);
        chk("post_rst_lat_data", dout_data, 36);
        drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
